// File: rtl/jacobi_sweep_ctrl.sv
// Jacobi sweep sequencer: fetches up/down/centre rows for each interior row and
// writes the stencil result into the destination grid. Includes its protocol checker.
module jacobi_sweep_ctrl_chk (
    input logic clock,
    input logic reset_n,
    input logic busy,
    input logic done,
    input logic cfg_err,
    input logic WE,
    input logic nb_valid
);

    // busy drops in the same cycle done is pulsed
    ap_done_not_busy: assert property (@(posedge clock) disable iff (!reset_n)
        !(busy && done));

    // writes and neighbour data only exist inside an accepted sweep
    ap_we_busy: assert property (@(posedge clock) disable iff (!reset_n)
        WE |-> busy);

    // neighbour rows are only presented during an accepted sweep
    ap_nb_busy: assert property (@(posedge clock) disable iff (!reset_n)
        nb_valid |-> busy);

    // done is a single-cycle pulse
    ap_done_pulse: assert property (@(posedge clock) disable iff (!reset_n)
        done |=> !done);

    // rejected starts never open a sweep
    ap_err_idle: assert property (@(posedge clock) disable iff (!reset_n)
        cfg_err |-> !busy);

endmodule

module jacobi_sweep_ctrl #(
    parameter int AW = 8,
    parameter int DW = 192
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  logic [AW-1:0] SrcBase,
    input  logic [AW-1:0] DstBase,
    input  logic [AW-1:0] NumRows,
    output logic          busy,
    output logic          done,
    output logic          cfg_err,
    output logic [AW-1:0] ReadAddress1,
    output logic [AW-1:0] ReadAddress2,
    input  logic [DW-1:0] ReadBus1,
    input  logic [DW-1:0] ReadBus2,
    output logic          WE,
    output logic [AW-1:0] WriteAddress,
    output logic [DW-1:0] WriteBus,
    output logic          nb_valid,
    output logic [DW-1:0] UpRow,
    output logic [DW-1:0] DnRow,
    output logic [DW-1:0] CtrRow,
    output logic [AW-1:0] row_idx,
    input  logic          res_valid,
    input  logic [DW-1:0] ResultBus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_UD    = 3'd1,
        RD_C     = 3'd2,
        WAIT_RES = 3'd3,
        WRITE    = 3'd4
    } state_t;

    localparam logic [AW:0]   ONE_W   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   MAX_ROW = {1'b0, {AW{1'b1}}};
    localparam logic [AW-1:0] ONE_A   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] TWO_A   = ONE_A + ONE_A;
    localparam logic [AW-1:0] THREE_A = TWO_A + ONE_A;

    // Range checks are done one bit wider so an overflowing top halo is caught.
    function automatic logic cfgReject(input logic [AW-1:0] src,
                                       input logic [AW-1:0] dst,
                                       input logic [AW-1:0] num);
        logic [AW:0] srcLo;
        logic [AW:0] srcHi;
        logic [AW:0] dstLo;
        logic [AW:0] dstHi;
        logic [AW:0] dstTop;
        srcLo  = {1'b0, src};
        srcHi  = {1'b0, src} + {1'b0, num} + ONE_W;
        dstLo  = {1'b0, dst} + ONE_W;
        dstHi  = {1'b0, dst} + {1'b0, num};
        dstTop = dstHi + ONE_W;
        cfgReject = (num == {AW{1'b0}}) || (srcHi > MAX_ROW) || (dstTop > MAX_ROW) ||
                    ((srcLo <= dstHi) && (dstLo <= srcHi));
    endfunction

    state_t        state_r;
    state_t        nextState_s;
    logic [AW-1:0] srcBase_r;
    logic [AW-1:0] dstBase_r;
    logic [AW-1:0] numRows_r;
    logic [AW-1:0] srcBase_s;
    logic [AW-1:0] dstBase_s;
    logic [AW-1:0] numRows_s;
    logic [AW-1:0] rowIdx_s;
    logic          busy_s;
    logic          done_s;
    logic          cfgErr_s;
    logic [AW-1:0] readAddr1_s;
    logic [AW-1:0] readAddr2_s;
    logic          we_s;
    logic [AW-1:0] writeAddr_s;
    logic [DW-1:0] writeBus_s;
    logic          nbValid_s;
    logic [DW-1:0] upRow_s;
    logic [DW-1:0] dnRow_s;
    logic [DW-1:0] ctrRow_s;
    logic          cfgBad_s;
    logic          lastRow_s;

    assign cfgBad_s  = cfgReject(SrcBase, DstBase, NumRows);
    assign lastRow_s = (row_idx == (numRows_r - ONE_A));

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next-state decode
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (start && !cfgBad_s) begin
                    nextState_s = RD_UD;
                end else begin
                    nextState_s = IDLE;
                end
            end
            RD_UD:    nextState_s = RD_C;
            RD_C:     nextState_s = WAIT_RES;
            WAIT_RES: begin
                if (res_valid) begin
                    nextState_s = WRITE;
                end else begin
                    nextState_s = WAIT_RES;
                end
            end
            WRITE: begin
                if (lastRow_s) begin
                    nextState_s = IDLE;
                end else begin
                    nextState_s = RD_UD;
                end
            end
            default: nextState_s = IDLE;
        endcase
    end

    // Next values for every registered output and latched configuration
    always_comb begin
        srcBase_s   = srcBase_r;
        dstBase_s   = dstBase_r;
        numRows_s   = numRows_r;
        rowIdx_s    = row_idx;
        busy_s      = busy;
        done_s      = 1'b0;
        cfgErr_s    = 1'b0;
        readAddr1_s = ReadAddress1;
        readAddr2_s = ReadAddress2;
        we_s        = WE;
        writeAddr_s = WriteAddress;
        writeBus_s  = WriteBus;
        nbValid_s   = nb_valid;
        upRow_s     = UpRow;
        dnRow_s     = DnRow;
        ctrRow_s    = CtrRow;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (cfgBad_s) begin
                        cfgErr_s = 1'b1;
                    end else begin
                        srcBase_s   = SrcBase;
                        dstBase_s   = DstBase;
                        numRows_s   = NumRows;
                        rowIdx_s    = {AW{1'b0}};
                        busy_s      = 1'b1;
                        readAddr1_s = SrcBase;
                        readAddr2_s = SrcBase + TWO_A;
                    end
                end else begin
                    busy_s = 1'b0;
                end
            end
            RD_UD: begin
                upRow_s     = ReadBus1;
                dnRow_s     = ReadBus2;
                readAddr1_s = srcBase_r + row_idx + ONE_A;
            end
            RD_C: begin
                ctrRow_s  = ReadBus1;
                nbValid_s = 1'b1;
            end
            WAIT_RES: begin
                if (res_valid) begin
                    we_s        = 1'b1;
                    writeAddr_s = dstBase_r + row_idx + ONE_A;
                    writeBus_s  = ResultBus;
                    nbValid_s   = 1'b0;
                end else begin
                    nbValid_s = 1'b1;
                end
            end
            WRITE: begin
                we_s = 1'b0;
                if (lastRow_s) begin
                    busy_s = 1'b0;
                    done_s = 1'b1;
                end else begin
                    rowIdx_s    = row_idx + ONE_A;
                    readAddr1_s = srcBase_r + row_idx + ONE_A;
                    readAddr2_s = srcBase_r + row_idx + THREE_A;
                end
            end
            default: begin
                busy_s    = 1'b0;
                we_s      = 1'b0;
                nbValid_s = 1'b0;
            end
        endcase
    end

    // Output and configuration registers; reset clears WE immediately
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            srcBase_r    <= {AW{1'b0}};
            dstBase_r    <= {AW{1'b0}};
            numRows_r    <= {AW{1'b0}};
            row_idx      <= {AW{1'b0}};
            busy         <= 1'b0;
            done         <= 1'b0;
            cfg_err      <= 1'b0;
            ReadAddress1 <= {AW{1'b0}};
            ReadAddress2 <= {AW{1'b0}};
            WE           <= 1'b0;
            WriteAddress <= {AW{1'b0}};
            WriteBus     <= {DW{1'b0}};
            nb_valid     <= 1'b0;
            UpRow        <= {DW{1'b0}};
            DnRow        <= {DW{1'b0}};
            CtrRow       <= {DW{1'b0}};
        end else begin
            srcBase_r    <= srcBase_s;
            dstBase_r    <= dstBase_s;
            numRows_r    <= numRows_s;
            row_idx      <= rowIdx_s;
            busy         <= busy_s;
            done         <= done_s;
            cfg_err      <= cfgErr_s;
            ReadAddress1 <= readAddr1_s;
            ReadAddress2 <= readAddr2_s;
            WE           <= we_s;
            WriteAddress <= writeAddr_s;
            WriteBus     <= writeBus_s;
            nb_valid     <= nbValid_s;
            UpRow        <= upRow_s;
            DnRow        <= dnRow_s;
            CtrRow       <= ctrRow_s;
        end
    end

    jacobi_sweep_ctrl_chk chk (
        .clock    (clock),
        .reset_n  (reset_n),
        .busy     (busy),
        .done     (done),
        .cfg_err  (cfg_err),
        .WE       (WE),
        .nb_valid (nb_valid)
    );

endmodule

// File: doc/jacobi_sweep_ctrl.md
# jacobi_sweep_ctrl

Sequencer for one Jacobi relaxation sweep over the 256×192-bit grid SRAM: 1 write port, 2 asynchronous read ports, 1 ns read delay. For each interior row it fetches the up, down and centre rows through the two read ports and presents them to the stencil compute unit. It then writes the returned result row into a separate destination region. The block sits between the top-level iteration control and the SRAM/compute datapath, and it is the only driver of the SRAM address and write-enable inputs.

## Interface
- AW, 8: SRAM address width (256 rows).
- DW, 192: SRAM row width.
- clock  in  1  rising-edge clock, shared with SRAM.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle sweep request. Sampled only in IDLE.
- SrcBase  in  AW  address of the top halo row of the source grid.
- DstBase  in  AW  address of the top halo row of the destination grid.
- NumRows  in  AW  number of interior rows to update, 1..254.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the last row write completes.
- cfg_err  out  1  one-cycle pulse when a start is rejected.
- ReadAddress1, ReadAddress2  out  AW  registered SRAM read addresses.
- ReadBus1, ReadBus2  in  DW  SRAM read data.
- WE  out  1  registered SRAM write enable.
- WriteAddress  out  AW  registered SRAM write address.
- WriteBus  out  DW  registered SRAM write data.
- nb_valid  out  1  UpRow, DnRow and CtrRow are valid. Held high while waiting for a result.
- UpRow, DnRow, CtrRow  out  DW  captured neighbour rows.
- row_idx  out  AW  current interior row index k (0-based).
- res_valid  in  1  compute result valid. Only honoured while nb_valid = 1.
- ResultBus  in  DW  compute result row.

## Operation
- States: IDLE, RD_UD, RD_C, WAIT_RES, WRITE.
- Start checks:
  - All address arithmetic is 9-bit unsigned.
  - In IDLE with start = 1, the request is rejected if any of the following holds: NumRows = 0; SrcBase + NumRows + 1 > 255; DstBase + NumRows + 1 > 255; ranges [SrcBase, SrcBase+NumRows+1] and [DstBase+1, DstBase+NumRows] overlap.
  - On rejection: pulse cfg_err, stay in IDLE.
  - Otherwise: latch SrcBase, DstBase and NumRows; set k = 0; go to RD_UD.
- Per-row sequence:
  - Entering RD_UD: ReadAddress1 = Src+k, ReadAddress2 = Src+k+2.
  - Leaving RD_UD: capture UpRow = ReadBus1, DnRow = ReadBus2. Set ReadAddress1 = Src+k+1. Go to RD_C.
  - Leaving RD_C: capture CtrRow = ReadBus1, set nb_valid = 1. Go to WAIT_RES.
  - WAIT_RES: remain here until res_valid = 1. No timeout.
  - On the res_valid edge: WE = 1, WriteAddress = Dst+k+1, WriteBus = ResultBus, nb_valid = 0. Go to WRITE.
  - Leaving WRITE: WE = 0.
    - If k = NumRows−1: go to IDLE, pulse done, clear busy.
    - Otherwise: k = k+1, go to RD_UD.
- start while busy is ignored. It raises no error and is not queued.
- res_valid outside WAIT_RES is ignored.
- Halo rows (Src, Src+NumRows+1 and the destination halos) are never written.
- Reset mid-sweep returns to IDLE immediately. WE is deasserted asynchronously, the sweep is abandoned, and rows already written stay written.

## Timing
- Reset values:
  - All outputs are 0, including WE, busy, done, cfg_err, nb_valid, every address output, WriteBus, UpRow, DnRow, CtrRow and row_idx.
  - State is IDLE.
- All outputs are registered. No combinational path runs from inputs to outputs.
- Read timing: a read address is stable for one full cycle before its data is captured, which covers the 1 ns SRAM read delay.
- Write timing: WE, WriteAddress and WriteBus are stable for the entire WRITE cycle. The SRAM commits the row on the edge leaving WRITE.
- Latency:
  - start edge → busy high on the next cycle.
  - The minimum per-row cost is 4 cycles, with res_valid high on the first WAIT_RES cycle.
  - A sweep therefore takes 4·NumRows cycles from the start edge to the done edge, plus any compute stalls.
- done and busy = 0 appear in the same cycle.
- A new start is accepted in the cycle done is high, since the block is already in IDLE.
- cfg_err is asserted the cycle after the rejected start.

## Test plan
- Nominal sweep:
  - Stimulus: Src = 0, Dst = 128, NumRows = 3, source row r preloaded with r; compute model returns CtrRow+1 immediately.
  - Required: rows 129..131 = 2,3,4; done at cycle 12 after start; WE asserted exactly 3 cycles; rows 128 and 132 untouched.
- Compute stall:
  - Stimulus: res_valid delayed 5 cycles on row 1.
  - Required: nb_valid held 6 cycles with UpRow, DnRow, CtrRow stable; write occurs only after res_valid; done at cycle 17.
- Config errors:
  - Stimulus: NumRows = 0; then Src = 250 with NumRows = 10; then Src = 0, Dst = 2, NumRows = 4 (overlap).
  - Required: cfg_err pulses each time; busy stays 0; WE never asserted.
- Start while busy:
  - Stimulus: second start with different bases in mid-sweep.
  - Required: ignored; original sweep completes unchanged; single done pulse.
- Reset mid-operation:
  - Stimulus: reset_n low during a WRITE cycle.
  - Required: WE = 0 within the same cycle; all outputs 0; a following start runs normally.
- Back-to-back sweeps:
  - Stimulus: start asserted in the done cycle with Src and Dst swapped.
  - Required: accepted; second sweep reads the first sweep's results.
